// File: rtl/pc_predict_if.sv
// Fetch-side bundle for the PC predictor: stall/BTB lookup, branch resolution
// from execute, and the predicted fetch stream. The statistics counters are
// only present when PC_PREDICT_STATS_EN is defined.
interface pc_predict_if;
  logic        stall;
  logic        btb_hit;
  logic [15:0] btb_target;
  logic        resolve_valid;
  logic [15:0] resolve_pc;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic        resolve_pred_taken;
  logic [15:0] resolve_pred_target;
  logic [15:0] pc_out;
  logic        pred_taken;
  logic [15:0] next_pc;
  logic        flush;
`ifdef PC_PREDICT_STATS_EN
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  modport slave (
    input  stall, btb_hit, btb_target, resolve_valid, resolve_pc,
           resolve_taken, resolve_target, resolve_pred_taken, resolve_pred_target,
    output pc_out, pred_taken, next_pc, flush, branch_count, mispredict_count
  );
  modport master (
    output stall, btb_hit, btb_target, resolve_valid, resolve_pc,
           resolve_taken, resolve_target, resolve_pred_taken, resolve_pred_target,
    input  pc_out, pred_taken, next_pc, flush, branch_count, mispredict_count
  );
`else
  modport slave (
    input  stall, btb_hit, btb_target, resolve_valid, resolve_pc,
           resolve_taken, resolve_target, resolve_pred_taken, resolve_pred_target,
    output pc_out, pred_taken, next_pc, flush
  );
  modport master (
    output stall, btb_hit, btb_target, resolve_valid, resolve_pc,
           resolve_taken, resolve_target, resolve_pred_taken, resolve_pred_target,
    input  pc_out, pred_taken, next_pc, flush
  );
`endif
endinterface

// File: rtl/pc_predict.sv
// Fetch PC generator with a 16-entry 2-bit bimodal PHT (indexed by pc[4:1])
// gated by an external BTB hit. Mispredicts from execute redirect fetch in
// the same cycle, overriding stall. Optional macro PC_PREDICT_STATS_EN adds
// saturating branch / mispredict counters.
module pc_predict (
  input  logic         clk,
  input  logic         reset,
  pc_predict_if.slave  bus
);

  localparam int PHT_N = 16;

  logic [1:0]  r_pht [PHT_N];
  logic [15:0] r_pc;

  logic [1:0]  w_pht_rd;
  logic        w_pred_taken;
  logic        w_mispredict;
  logic [15:0] w_next_pc;
  logic [3:0]  w_upd_idx;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    return (v == 2'b00) ? v : v - 2'b01;
  endfunction

  // PHT read is of the registered array, so a same-cycle update is not bypassed
  assign w_pht_rd     = r_pht[r_pc[4:1]];
  assign w_pred_taken = bus.btb_hit & w_pht_rd[1];
  assign w_upd_idx    = bus.resolve_pc[4:1];

  // Direction mismatch, or taken with a wrong target; not-taken ignores targets
  assign w_mispredict = bus.resolve_valid &
                        ((bus.resolve_taken != bus.resolve_pred_taken) |
                         (bus.resolve_taken & (bus.resolve_target != bus.resolve_pred_target)));

  // Next fetch PC selection: reset, redirect, stall, predicted-taken, sequential
  always_comb begin
    w_next_pc = r_pc + 16'd2;
    if (reset) begin
      w_next_pc = 16'h0000;
    end else if (w_mispredict) begin
      w_next_pc = bus.resolve_taken ? bus.resolve_target : (bus.resolve_pc + 16'd2);
    end else if (bus.stall) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = bus.btb_target;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= 16'h0000;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // PHT training on every resolved branch, independent of stall
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (bus.resolve_valid) begin
      r_pht[w_upd_idx] <= bus.resolve_taken ? sat_inc2(r_pht[w_upd_idx])
                                            : sat_dec2(r_pht[w_upd_idx]);
    end
  end

  assign bus.pc_out     = r_pc;
  assign bus.pred_taken = w_pred_taken;
  assign bus.next_pc    = w_next_pc;
  assign bus.flush      = w_mispredict;

`ifdef PC_PREDICT_STATS_EN
  logic [15:0] r_branch_count;
  logic [15:0] r_mispredict_count;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating resolve / mispredict statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_count     <= 16'h0000;
      r_mispredict_count <= 16'h0000;
    end else begin
      if (bus.resolve_valid) r_branch_count     <= sat_inc16(r_branch_count);
      if (w_mispredict)      r_mispredict_count <= sat_inc16(r_mispredict_count);
    end
  end

  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;
`endif

endmodule
